me_result_fifo: RTL and testbench

//  Downstream stage of the ME top level. Captures one (MSAD, column, row) result per
//  8x8 block on data_valid rising edge; converts column/row to signed motion vectors;

---
 rtl/me_result_fifo_if.sv | 36 +++
 rtl/me_result_fifo.sv | 154 +++++++++++++++
 tb/tb_me_result_fifo.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/me_result_fifo_if.sv
// Result stream leaving the motion-estimation result FIFO: head entry payload
// plus a valid/ready handshake. The FIFO drives it as master; the consumer is slave.
interface me_result_fifo_if #(
   parameter int SAD_BIT_WIDTH = 14
);
   logic                     out_valid;
   logic                     out_ready;
   logic [SAD_BIT_WIDTH-1:0] out_sad;
   logic [5:0]               out_mv_x;
   logic [5:0]               out_mv_y;
   logic [3:0]               out_blk_x;
   logic [3:0]               out_blk_y;
   logic                     out_last;

   modport master (
      output out_valid,
      output out_sad,
      output out_mv_x,
      output out_mv_y,
      output out_blk_x,
      output out_blk_y,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_sad,
      input  out_mv_x,
      input  out_mv_y,
      input  out_blk_x,
      input  out_blk_y,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/me_result_fifo.sv
// Captures one ME result per 8x8 block on the rising edge of data_valid, converts it
// to a signed motion vector tagged with its block position, and queues it (FWFT FIFO).
module me_result_fifo #(
   parameter int SAD_BIT_WIDTH  = 14,
   parameter int FIFO_DEPTH     = 8,
   parameter int BLOCKS_PER_ROW = 4,
   parameter int BLOCK_ROWS     = 4,
   parameter int MV_OFFSET      = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear_i,
   input  logic                          data_valid,
   input  logic [SAD_BIT_WIDTH-1:0]      MSAD,
   input  logic [4:0]                    MSAD_column,
   input  logic [4:0]                    MSAD_row,
   me_result_fifo_if.master              out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          frame_done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [3:0]    BX_MAX = 4'(BLOCKS_PER_ROW - 1);
   localparam logic [3:0]    BY_MAX = 4'(BLOCK_ROWS - 1);
   localparam logic [5:0]    MV_OFF = 6'(MV_OFFSET);
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [SAD_BIT_WIDTH-1:0] sad;
      logic [5:0]               mv_x;
      logic [5:0]               mv_y;
      logic [3:0]               blk_x;
      logic [3:0]               blk_y;
      logic                     last;
   } entry_t;

   // Payload storage carries no reset: contents are only meaningful below count_reg.
   entry_t          mem [FIFO_DEPTH];

   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [3:0]      bx_reg;
   logic [3:0]      by_reg;
   logic            dv_q_reg;
   logic            overflow_reg;
   logic            frame_done_reg;

   logic            cap;
   logic            empty;
   logic            full;
   logic            pop;
   logic            push;
   logic            blk_last;
   entry_t          new_entry;
   entry_t          head;

   always_comb begin
      cap      = data_valid & ~dv_q_reg;
      empty    = (count_reg == '0);
      full     = (count_reg == FULL_COUNT);
      pop      = ~empty & out.out_ready;
      // A full FIFO still accepts a result when the head leaves in the same cycle.
      push     = cap & (~full | pop);
      blk_last = (bx_reg == BX_MAX) && (by_reg == BY_MAX);
      head     = mem[rd_ptr_reg];

      new_entry       = '0;
      new_entry.sad   = MSAD;
      new_entry.mv_x  = {1'b0, MSAD_column} - MV_OFF;
      new_entry.mv_y  = {1'b0, MSAD_row} - MV_OFF;
      new_entry.blk_x = bx_reg;
      new_entry.blk_y = by_reg;
      new_entry.last  = blk_last;
   end

   always_ff @(posedge clk) begin
      if (push && !clear_i) begin
         mem[wr_ptr_reg] <= new_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         bx_reg         <= '0;
         by_reg         <= '0;
         dv_q_reg       <= 1'b0;
         overflow_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
      end else if (clear_i) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         bx_reg         <= '0;
         by_reg         <= '0;
         // Tracking the live level means a data_valid already high is not a new result.
         dv_q_reg       <= data_valid;
         overflow_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         dv_q_reg       <= data_valid;
         frame_done_reg <= pop & head.last;

         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end

         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase

         // Block position advances on dropped results too, so later tags stay aligned.
         if (cap) begin
            if (blk_last) begin
               bx_reg <= '0;
               by_reg <= '0;
            end else if (bx_reg == BX_MAX) begin
               bx_reg <= '0;
               by_reg <= by_reg + 1'b1;
            end else begin
               bx_reg <= bx_reg + 1'b1;
            end
            if (!push) begin
               overflow_reg <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      out.out_valid = ~empty;
      out.out_sad   = empty ? '0 : head.sad;
      out.out_mv_x  = empty ? '0 : head.mv_x;
      out.out_mv_y  = empty ? '0 : head.mv_y;
      out.out_blk_x = empty ? '0 : head.blk_x;
      out.out_blk_y = empty ? '0 : head.blk_y;
      out.out_last  = empty ? 1'b0 : head.last;
   end

   assign fifo_count = count_reg;
   assign overflow   = overflow_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_me_result_fifo.sv
// Scoreboard bench for me_result_fifo: the driver predicts each stored result from
// block-order arithmetic; a negedge monitor checks the head on every handshake.
module tb_me_result_fifo;

   localparam int SW    = 14;
   localparam int DEPTH = 8;
   localparam int BPR   = 4;
   localparam int BR    = 4;
   localparam int OFF   = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic          clear_i;
   logic          data_valid;
   logic [SW-1:0] MSAD;
   logic [4:0]    col;
   logic [4:0]    row;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic          frame_done;

   me_result_fifo_if #(.SAD_BIT_WIDTH(SW)) rif ();

   me_result_fifo #(
      .SAD_BIT_WIDTH (SW),
      .FIFO_DEPTH    (DEPTH),
      .BLOCKS_PER_ROW(BPR),
      .BLOCK_ROWS    (BR),
      .MV_OFFSET     (OFF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear_i),
      .data_valid (data_valid),
      .MSAD       (MSAD),
      .MSAD_column(col),
      .MSAD_row   (row),
      .out        (rif),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .frame_done (frame_done)
   );

   typedef struct {
      int sad;
      int mvx;
      int mvy;
      int bx;
      int by;
      int last;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   m_cnt = 0;
   int   m_ovf = 0;
   int   cap_idx = 0;
   bit   m_dv_prev = 0;
   int   exp_cnt_now = 0;
   int   exp_ovf_now = 0;
   bit   mon_en = 0;
   int   fd_pulses = 0;
   int   fd_next = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("[TB] FAIL %s: got %0d required %0d", name, $signed(got), $signed(want));
      end
   endfunction

   function automatic int mv_of(input int v);
      int w;
      w = v - OFF;
      w = ((w % 64) + 64) % 64;
      if (w >= 32) w -= 64;
      return w;
   endfunction

   // Drive one cycle of inputs and predict what the following clock edge does.
   task automatic cycle(input bit dv, input int sad, input int c, input int r,
                        input bit rdy, input bit clr);
      bit   cap;
      bit   pop;
      int   idx;
      exp_t e;
      @(posedge clk);
      #1;
      exp_cnt_now   = m_cnt;
      exp_ovf_now   = m_ovf;
      mon_en        = 1'b1;
      data_valid    = dv;
      MSAD          = SW'(sad);
      col           = 5'(c);
      row           = 5'(r);
      rif.out_ready = clr ? 1'b0 : rdy;
      clear_i       = clr;
      if (clr) begin
         exp_q.delete();
         m_cnt   = 0;
         m_ovf   = 0;
         cap_idx = 0;
      end else begin
         cap = dv && !m_dv_prev;
         pop = (m_cnt > 0) && rif.out_ready;
         if (pop) m_cnt--;
         if (cap) begin
            if (m_cnt < DEPTH) begin
               idx    = cap_idx % (BPR * BR);
               e.sad  = sad % (1 << SW);
               e.mvx  = mv_of(c);
               e.mvy  = mv_of(r);
               e.bx   = idx % BPR;
               e.by   = idx / BPR;
               e.last = (idx == BPR * BR - 1) ? 1 : 0;
               exp_q.push_back(e);
               m_cnt++;
            end else begin
               m_ovf = 1;
            end
            cap_idx++;
         end
      end
      m_dv_prev = dv;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      mon_en        = 1'b0;
      rst           = 1'b1;
      data_valid    = 1'b0;
      clear_i       = 1'b0;
      rif.out_ready = 1'b0;
      #1;
      chk("async_rst_count", 32'(fifo_count), 0);
      chk("async_rst_valid", 32'(rif.out_valid), 0);
      exp_q.delete();
      m_cnt     = 0;
      m_ovf     = 0;
      cap_idx   = 0;
      m_dv_prev = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: state checks every cycle, payload checks on each accepted head entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!mon_en || rst) begin
            fd_next = 0;
         end else begin
            chk("fifo_count", 32'(fifo_count), exp_cnt_now);
            chk("out_valid", 32'(rif.out_valid), (exp_cnt_now != 0) ? 1 : 0);
            chk("overflow", 32'(overflow), exp_ovf_now);
            chk("frame_done", 32'(frame_done), fd_next);
            if (frame_done === 1'b1) fd_pulses++;
            fd_next = 0;
            if (rif.out_valid === 1'b1 && rif.out_ready === 1'b1) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("[TB] FAIL pop_unexpected: got out_valid=1 required no entry");
               end else begin
                  e = exp_q.pop_front();
                  chk("out_sad", 32'(rif.out_sad), e.sad);
                  chk("out_mv_x", 32'($signed(rif.out_mv_x)), e.mvx);
                  chk("out_mv_y", 32'($signed(rif.out_mv_y)), e.mvy);
                  chk("out_blk_x", 32'(rif.out_blk_x), e.bx);
                  chk("out_blk_y", 32'(rif.out_blk_y), e.by);
                  chk("out_last", 32'(rif.out_last), e.last);
                  fd_next = e.last;
                  $display("[TB] pop sad=%0d mv=(%0d,%0d) blk=(%0d,%0d) last=%0d",
                           e.sad, e.mvx, e.mvy, e.bx, e.by, e.last);
               end
            end
         end
      end
   end

   initial begin
      int fd0;
      rst           = 1'b1;
      clear_i       = 1'b0;
      data_valid    = 1'b0;
      MSAD          = '0;
      col           = '0;
      row           = '0;
      rif.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_valid", 32'(rif.out_valid), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_sad", 32'(rif.out_sad), 0);
      chk("rst_tag", 32'({rif.out_blk_x, rif.out_blk_y, rif.out_last}), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single pulse: visible one edge later with mv=(+2,-3) at block (0,0).
      cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
      cycle(1'b1, 100, 10, 5, 1'b0, 1'b0);
      cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
      chk("t1_valid", 32'(rif.out_valid), 1);
      chk("t1_sad", 32'(rif.out_sad), 100);
      chk("t1_mv_x", 32'($signed(rif.out_mv_x)), 2);
      chk("t1_mv_y", 32'($signed(rif.out_mv_y)), -3);
      chk("t1_blk", 32'({rif.out_blk_x, rif.out_blk_y}), 0);
      cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);

      // Level held high for five cycles is one result.
      cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
      repeat (5) cycle(1'b1, 77, 3, 30, 1'b0, 1'b0);
      cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
      chk("t2_count", 32'(fifo_count), 1);
      repeat (2) cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);

      // Full frame streamed through, then the first block of the next frame.
      cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
      fd0 = fd_pulses;
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, $urandom_range(0, 16383), $urandom_range(0, 31), $urandom_range(0, 31), 1'b1, 1'b0);
         cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
      end
      repeat (3) cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
      chk("t3_frame_done_pulses", 32'(fd_pulses - fd0), 1);
      cycle(1'b1, 55, 8, 8, 1'b1, 1'b0);
      cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
      cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);

      // Nine results into a stalled FIFO: eight kept, one dropped.
      cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         cycle(1'b1, 1000 + i, i, 31 - i, 1'b0, 1'b0);
         cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
      end
      chk("t4_count", 32'(fifo_count), DEPTH);
      chk("t4_overflow", 32'(overflow), 1);
      repeat (5) cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
      cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
      chk("t6_pre_count", 32'(fifo_count), 3);
      cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
      cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
      chk("t6_count", 32'(fifo_count), 0);
      chk("t6_valid", 32'(rif.out_valid), 0);
      chk("t6_overflow", 32'(overflow), 0);

      // Full FIFO with a simultaneous pop accepts the new result.
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, 200 + i, 16 + i, i, 1'b0, 1'b0);
         cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
      end
      cycle(1'b1, 999, 0, 31, 1'b1, 1'b0);
      cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
      chk("t5_count", 32'(fifo_count), DEPTH);
      chk("t5_overflow", 32'(overflow), 0);
      repeat (10) cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);

      // Clear with data_valid already high must not capture.
      cycle(1'b1, 5, 5, 5, 1'b0, 1'b1);
      cycle(1'b1, 5, 5, 5, 1'b0, 1'b0);
      cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
      chk("clear_high_level_count", 32'(fifo_count), 0);

      // Randomised traffic with occasional clears and one mid-run reset.
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset();
         cycle($urandom_range(0, 2) != 0, $urandom_range(0, 16383), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 9) < 6, $urandom_range(0, 149) == 0);
      end
      repeat (DEPTH + 4) cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
      cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
      chk("final_drained", 32'(exp_q.size()), 0);
      chk("final_count", 32'(fifo_count), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
